// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops (add, sub, and, or, shifts, compares, xor, reserved) are
// registered on the accept edge. Op 11 (unsigned multiply) runs an iterative
// shift-add over WIDTH cycles and returns the low WIDTH bits of the product.
// Overflow is reported for add, sub and multiply only.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; a, b, op, shift_amt sampled on accept
//   a, b                signed two's-complement operands
//   op                  operation code (0-11 defined, 12-15 reserved -> 0)
//   shift_amt           shift distance for ops 4-6 (b is ignored for shifts)
//   out_valid/out_ready result handshake; result/overflow held while stalled
//   result, overflow    registered result and overflow flag
//
// Optional: define ALU_FLAGS_EN to add registered zero, negative and carry
// outputs (carry = add carry-out, or a>=b unsigned for sub; 0 otherwise).

module alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         op,
  input  logic [SHAMT_W-1:0] shift_amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
`ifdef ALU_FLAGS_EN
  ,
  output logic               zero,
  output logic               negative,
  output logic               carry
`endif
);

  localparam int                 MSB    = WIDTH - 1;
  localparam logic [3:0]         OP_MUL = 4'd11;
  localparam logic [SHAMT_W-1:0] LAST   = SHAMT_W'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t state, state_next;

  logic               accept;
  logic               mul_last;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ov;
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [SHAMT_W-1:0] cnt;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_x, sub_x;
  logic           alu_carry;
  assign add_x = {1'b0, a} + {1'b0, b};
  assign sub_x = {1'b0, a} - {1'b0, b};
  assign sum   = add_x[MSB:0];
  assign diff  = sub_x[MSB:0];
  // Subtract reports "no borrow" (a >= b unsigned), the inverse of sub_x[WIDTH].
  always_comb begin
    alu_carry = 1'b0;
    if (op == 4'd0) alu_carry = add_x[WIDTH];
    else if (op == 4'd1) alu_carry = ~sub_x[WIDTH];
  end
`else
  assign sum  = a + b;
  assign diff = a - b;
`endif

  // Single-cycle datapath; the op 11 arm is unused because multiply
  // results come from the accumulator.
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum;
        alu_ov  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      4'd1: begin
        alu_res = diff;
        alu_ov  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      4'd2:  alu_res = a & b;
      4'd3:  alu_res = a | b;
      4'd4:  alu_res = a << shift_amt;
      4'd5:  alu_res = a >> shift_amt;
      4'd6:  alu_res = $signed(a) >>> shift_amt;
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      4'd8:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:  alu_res = a ^ b;
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: begin
        alu_res = '0;
        alu_ov  = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  always_comb begin
    state_next = state;
    mul_last   = 1'b0;
    case (state)
      IDLE: if (accept && op == OP_MUL) state_next = MUL;
      MUL: begin
        if (cnt == LAST) begin
          state_next = IDLE;
          mul_last   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
`ifdef ALU_FLAGS_EN
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
`endif
    end else begin
      state <= state_next;

      // Retire first; a same-edge accept or multiply completion overrides.
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept) begin
        if (op == OP_MUL) begin
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          result    <= alu_res;
          overflow  <= alu_ov;
          out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
          zero      <= (alu_res == '0);
          negative  <= alu_res[MSB];
          carry     <= alu_carry;
`endif
        end
      end

      if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          result    <= acc_next[MSB:0];
          overflow  <= |acc_next[2*WIDTH-1:WIDTH];
          out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
          zero      <= (acc_next[MSB:0] == '0);
          negative  <= acc_next[MSB];
          carry     <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
